led_ctrl_multi: RTL and testbench

- Multi-channel successor to the single-channel LED function block.
- Each channel has two event sources:
  - a debounced manual key that toggles the LED ON/OFF;
  - a debounced occupancy-sensor (OS) input that lights the LED for a fixed timeout.
- Channel count, timeout length, retrigger behaviour, key-cancel behaviour and output polarity are parameters.
- Sits between the per-input debounce blocks and the LED drive pins.

---
 rtl/led_ctrl_multi.sv | 100 ++++++++++
 tb/tb_led_ctrl_multi.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED controller: each channel toggles on a key press or lights for a
// fixed timeout on an occupancy-sensor press, with a global synchronous force-off.
module led_ctrl_multi #(
    parameter int N_CH          = 4,
    parameter int TIMEOUT_TICKS = 105000000,
    parameter bit RETRIG        = 1'b0,
    parameter bit KEY_CANCEL    = 1'b1,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] key_lvl,
    input  logic [N_CH-1:0] os_lvl,
    input  logic            all_off,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] timed,
    output logic [N_CH-1:0] lit
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_ON_KEY   = 2'd1;
    localparam logic [1:0] ST_ON_TIMED = 2'd2;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_TICKS - 1);

    logic [N_CH-1:0] key_prev;
    logic [N_CH-1:0] os_prev;
    logic [N_CH-1:0] key_ev;
    logic [N_CH-1:0] os_ev;

    assign key_ev = key_lvl & ~key_prev;
    assign os_ev  = os_lvl  & ~os_prev;

    // Previous levels reset to 1 so inputs already held at reset release stay silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev <= '1;
            os_prev  <= '1;
        end else begin
            key_prev <= key_lvl;
            os_prev  <= os_lvl;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_OFF;
                cnt   <= '0;
            end else if (all_off) begin
                state <= ST_OFF;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (key_ev[g]) begin
                            state <= ST_ON_KEY;
                        end else if (os_ev[g]) begin
                            state <= ST_ON_TIMED;
                            cnt   <= RELOAD;
                        end
                    end
                    ST_ON_KEY: begin
                        if (key_ev[g]) begin
                            state <= ST_OFF;
                        end
                    end
                    ST_ON_TIMED: begin
                        // Key cancel outranks a retrigger arriving on the same edge.
                        if (key_ev[g] && KEY_CANCEL) begin
                            state <= ST_OFF;
                            cnt   <= '0;
                        end else if (os_ev[g] && RETRIG) begin
                            cnt   <= RELOAD;
                        end else if (cnt == '0) begin
                            state <= ST_OFF;
                        end else begin
                            cnt   <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_OFF;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign lit[g]   = (state != ST_OFF);
        assign timed[g] = (state == ST_ON_TIMED);
    end

    assign led = ACTIVE_LOW ? ~lit : lit;

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Directed bench for led_ctrl_multi: two 4-channel variants share stimulus, plus a
// 1-channel TIMEOUT_TICKS=1 variant for the minimum pulse.
module tb_led_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_lvl = '0;
    logic [3:0] os_lvl = '0;
    logic       all_off = 1'b0;
    logic [0:0] key_c = '0;
    logic [0:0] os_c = '0;

    logic [3:0] led_a, timed_a, lit_a;
    logic [3:0] led_b, timed_b, lit_b;
    logic [0:0] led_c, timed_c, lit_c;

    int n_compared = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    led_ctrl_multi #(.N_CH(4), .TIMEOUT_TICKS(10), .RETRIG(1'b0), .KEY_CANCEL(1'b1),
                     .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .key_lvl(key_lvl), .os_lvl(os_lvl), .all_off(all_off),
        .led(led_a), .timed(timed_a), .lit(lit_a));

    led_ctrl_multi #(.N_CH(4), .TIMEOUT_TICKS(10), .RETRIG(1'b1), .KEY_CANCEL(1'b0),
                     .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .key_lvl(key_lvl), .os_lvl(os_lvl), .all_off(all_off),
        .led(led_b), .timed(timed_b), .lit(lit_b));

    led_ctrl_multi #(.N_CH(1), .TIMEOUT_TICKS(1), .RETRIG(1'b0), .KEY_CANCEL(1'b1),
                     .ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst(rst), .key_lvl(key_c), .os_lvl(os_c), .all_off(all_off),
        .led(led_c), .timed(timed_c), .lit(lit_c));

    typedef struct {
        logic       rst;
        logic [3:0] key;
        logic [3:0] os;
        logic       all_off;
        logic [3:0] lit_a;
        logic [3:0] timed_a;
        logic [3:0] lit_b;
        logic [3:0] timed_b;
    } vec_t;

    vec_t vecs [27];

    task automatic apply_stimulus(input logic r, input logic [3:0] k, input logic [3:0] o,
                                  input logic ao);
        @(negedge clk);
        rst     = r;
        key_lvl = k;
        os_lvl  = o;
        all_off = ao;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_lit_a, input logic [3:0] e_timed_a,
                             input logic [3:0] e_lit_b, input logic [3:0] e_timed_b);
        check_output($sformatf("%s lit_a", tag), lit_a, e_lit_a);
        check_output($sformatf("%s timed_a", tag), timed_a, e_timed_a);
        check_output($sformatf("%s led_a", tag), led_a, ~e_lit_a);
        check_output($sformatf("%s lit_b", tag), lit_b, e_lit_b);
        check_output($sformatf("%s timed_b", tag), timed_b, e_timed_b);
        check_output($sformatf("%s led_b", tag), led_b, e_lit_b);
    endtask

    initial begin
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] o;
        logic [3:0] k;
        logic       r;
        logic       ec;

        // rst, key, os, all_off, lit_a, timed_a, lit_b, timed_b
        vecs[0]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        vecs[7]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
        vecs[9]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        vecs[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        vecs[11] = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0101, 4'b0000, 4'b0101, 4'b0000};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0101, 4'b0000, 4'b0101, 4'b0000};
        vecs[13] = '{1'b0, 4'b0000, 4'b1000, 1'b0, 4'b1101, 4'b1000, 4'b1101, 4'b1000};
        vecs[14] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[15] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[17] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
        vecs[18] = '{1'b0, 4'b0000, 4'b1000, 1'b0, 4'b1011, 4'b1000, 4'b1011, 4'b1000};
        vecs[19] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b1111, 4'b1000, 4'b1111, 4'b1000};
        vecs[20] = '{1'b0, 4'b0000, 4'b0100, 1'b0, 4'b1111, 4'b1000, 4'b1111, 4'b1000};
        vecs[21] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b1011, 4'b1000, 4'b1011, 4'b1000};
        vecs[22] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1011, 4'b1000, 4'b1011, 4'b1000};
        vecs[23] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 4'b0011, 4'b0000, 4'b1011, 4'b1000};
        vecs[24] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0011, 4'b0000, 4'b1011, 4'b1000};
        vecs[25] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[26] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        for (int i = 0; i < 27; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].key, vecs[i].os, vecs[i].all_off);
            check_all($sformatf("vec%0d", i), vecs[i].lit_a, vecs[i].timed_a,
                      vecs[i].lit_b, vecs[i].timed_b);
        end

        // Timeout on ch2 with a second press 4 cycles in: ignored by a, reloads b.
        for (int t = 0; t <= 16; t++) begin
            o  = (t == 0 || t == 4) ? 4'b0100 : 4'b0000;
            ea = (t <= 9)  ? 4'b0100 : 4'b0000;
            eb = (t <= 13) ? 4'b0100 : 4'b0000;
            apply_stimulus(1'b0, 4'b0000, o, 1'b0);
            check_all($sformatf("os_timeout t%0d", t), ea, ea, eb, eb);
        end

        // Key during ON_TIMED on ch1: cancels in a, ignored in b.
        for (int t = 0; t <= 12; t++) begin
            o  = (t == 0) ? 4'b0010 : 4'b0000;
            k  = (t == 2) ? 4'b0010 : 4'b0000;
            ea = (t <= 1) ? 4'b0010 : 4'b0000;
            eb = (t <= 9) ? 4'b0010 : 4'b0000;
            apply_stimulus(1'b0, k, o, 1'b0);
            check_all($sformatf("key_cancel t%0d", t), ea, ea, eb, eb);
        end

        // Reset mid-timeout on ch0 with OS held; only a fresh rise re-lights.
        for (int t = 0; t <= 9; t++) begin
            r  = (t == 3);
            o  = (t <= 6 || t >= 8) ? 4'b0001 : 4'b0000;
            ea = (t <= 2 || t >= 8) ? 4'b0001 : 4'b0000;
            apply_stimulus(r, 4'b0000, o, 1'b0);
            check_all($sformatf("rst_mid t%0d", t), ea, ea, ea, ea);
        end
        apply_stimulus(1'b0, 4'b0000, 4'b0001, 1'b1);
        check_all("force_off", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        check_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // TIMEOUT_TICKS=1 gives a single-cycle pulse; a held level does not re-fire.
        for (int t = 0; t <= 4; t++) begin
            os_c = (t == 0 || t == 1 || t == 3) ? 1'b1 : 1'b0;
            ec   = (t == 0 || t == 3);
            apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
            check_output($sformatf("min_pulse t%0d lit_c", t), {3'b000, lit_c}, {3'b000, ec});
            check_output($sformatf("min_pulse t%0d timed_c", t), {3'b000, timed_c}, {3'b000, ec});
            check_output($sformatf("min_pulse t%0d led_c", t), {3'b000, led_c}, {3'b000, ~ec});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
